// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and types for the Booth multiplier sequencer
//
// Purpose: state encoding, recoded Booth digit encoding and iteration
//          count shared by booth_mul_sequencer and booth_pair_recode.
// Ports:   none (package).

package mul_pkg;

  // Sequencer states, kept as plain constants for legacy compatibility.
  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_ITER = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  // Recoded digit is a 3-bit two's complement value in {-2..+2}.
  // Bit 2 is the sign, so negative digits can be detected with one bit.
  typedef enum logic [2:0] {
    DIGIT_ZERO = 3'b000,
    DIGIT_POS1 = 3'b001,
    DIGIT_POS2 = 3'b010,
    DIGIT_NEG2 = 3'b110,
    DIGIT_NEG1 = 3'b111
  } digitCode_t;

  // Default operand width and number of bit-pair iterations.
  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITERS = MUL_WIDTH / 2;

  // True when the digit selects the doubled multiplicand.
  function automatic logic digitIsDouble(input digitCode_t digit);
    return (digit == DIGIT_POS2) || (digit == DIGIT_NEG2);
  endfunction

  // True when the digit subtracts from the accumulator.
  function automatic logic digitIsNegative(input digitCode_t digit);
    return digit[2];
  endfunction

endpackage

// File: rtl/booth_pair_recode.sv
// rtl/booth_pair_recode.sv - radix-4 Booth recoder for one multiplier bit-pair window
//
// Purpose: maps the 3-bit window {y[2i+1], y[2i], y[2i-1]} onto a Booth
//          digit in {-2,-1,0,+1,+2}. Purely combinational.
// Ports:
//   window  in  3  multiplier window, bit 0 is the previously retired bit
//   digit   out 3  recoded digit (digitCode_t)

module booth_pair_recode
  import mul_pkg::*;
(
  input  logic [2:0]  window,
  output digitCode_t  digit
);

  always_comb begin
    digit = DIGIT_ZERO;
    case (window)
      3'b000:  digit = DIGIT_ZERO;
      3'b001:  digit = DIGIT_POS1;
      3'b010:  digit = DIGIT_POS1;
      3'b011:  digit = DIGIT_POS2;
      3'b100:  digit = DIGIT_NEG2;
      3'b101:  digit = DIGIT_NEG1;
      3'b110:  digit = DIGIT_NEG1;
      3'b111:  digit = DIGIT_ZERO;
      default: digit = DIGIT_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mul_sequencer.sv
// rtl/booth_mul_sequencer.sv - iterative radix-4 Booth signed multiplier sequencer
//
// Purpose: signed WIDTH x WIDTH multiply, one Booth bit-pair per clock,
//          WIDTH/2 iterations. Operands latch on start in IDLE; the
//          2*WIDTH product is loaded on the last iteration edge and a
//          registered one-cycle done pulse follows.
// Ports:
//   clock           in  1      rising-edge clock
//   clear           in  1      asynchronous active-high reset
//   start           in  1      multiply request, honoured only in IDLE
//   inX             in  WIDTH  multiplicand (two's complement)
//   inY             in  WIDTH  multiplier (two's complement)
//   busy            out 1      high from acceptance through the done cycle
//   done            out 1      one-cycle completion pulse
//   outProductHigh  out WIDTH  upper half of the signed product
//   outProductLow   out WIDTH  lower half of the signed product

module booth_mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] inX,
  input  logic [WIDTH-1:0] inY,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outProductHigh,
  output logic [WIDTH-1:0] outProductLow
);

  localparam int ITERS = WIDTH / 2;
  localparam int PW    = 2 * WIDTH;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(ITERS - 1);

  logic [1:0]     state;
  logic [PW-1:0]  mcand;
  logic [PW-1:0]  acc;
  logic [WIDTH:0] mplr;
  logic [CW-1:0]  count;

  digitCode_t     digit;
  logic           negDigit;
  logic [PW-1:0]  addend;
  logic [PW-1:0]  accNext;

  booth_pair_recode recoder (
    .window (mplr[2:0]),
    .digit  (digit)
  );

  // Subtraction is done as add of the inverted magnitude with carry-in,
  // so the datapath needs a single 2*WIDTH adder.
  always_comb begin
    negDigit = digitIsNegative(digit);
    addend   = '0;
    if (digit != DIGIT_ZERO) begin
      addend = digitIsDouble(digit) ? {mcand[PW-2:0], 1'b0} : mcand;
    end
    accNext = acc + (addend ^ {PW{negDigit}}) + {{(PW-1){1'b0}}, negDigit};
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state          <= STATE_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      outProductHigh <= '0;
      outProductLow  <= '0;
      acc            <= '0;
      mcand          <= '0;
      mplr           <= '0;
      count          <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= {{WIDTH{inX[WIDTH-1]}}, inX};
            mplr  <= {inY, 1'b0};
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= STATE_ITER;
          end
        end

        STATE_ITER: begin
          acc   <= accNext;
          mcand <= {mcand[PW-3:0], 2'b00};
          // Arithmetic shift keeps the sign for the top window.
          mplr  <= {{2{mplr[WIDTH]}}, mplr[WIDTH:2]};
          count <= count + CW'(1);
          if (count == LAST_COUNT) begin
            outProductHigh <= accNext[PW-1:WIDTH];
            outProductLow  <= accNext[WIDTH-1:0];
            done           <= 1'b1;
            state          <= STATE_DONE;
          end
        end

        STATE_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= STATE_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= STATE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// tb/tb_booth_mul_sequencer.sv - self-checking bench for booth_mul_sequencer

module tb_booth_mul_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] inX;
  logic [31:0] inY;
  logic        busy;
  logic        done;
  logic [31:0] outProductHigh;
  logic [31:0] outProductLow;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [63:0] shownProduct;

  booth_mul_sequencer #(.WIDTH(32)) dut (
    .clock          (clock),
    .clear          (clear),
    .start          (start),
    .inX            (inX),
    .inY            (inY),
    .busy           (busy),
    .done           (done),
    .outProductHigh (outProductHigh),
    .outProductLow  (outProductLow)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] refProduct(input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the DONE->IDLE edge,
  // which is the earliest point a new start can be presented.
  task automatic runMul(input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [63:0] expected;
    int          latency;
    int          busyCycles;
    logic        holdOk;
    expected   = refProduct(x, y);
    latency    = 0;
    busyCycles = 0;
    holdOk     = 1'b1;
    start = 1'b1;
    inX   = x;
    inY   = y;
    @(posedge clock);
    #1;
    start = 1'b0;
    inX   = $urandom;
    inY   = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (busy) busyCycles++;
      if (done) begin
        latency = k;
        break;
      end
      if ({outProductHigh, outProductLow} !== shownProduct) holdOk = 1'b0;
    end
    check({tag, " latency"}, 64'(latency), 64'd17);
    check({tag, " busy cycles"}, 64'(busyCycles), 64'd17);
    check({tag, " hold during iter"}, 64'(holdOk), 64'd1);
    check({tag, " product"}, {outProductHigh, outProductLow}, expected);
    shownProduct = expected;
    @(negedge clock);
    check({tag, " done pulse width"}, 64'({done, busy}), 64'd0);
    check({tag, " product held"}, {outProductHigh, outProductLow}, expected);
  endtask

  initial begin
    int          doneCount;
    logic [63:0] doneValue;

    clear        = 1'b1;
    start        = 1'b0;
    inX          = '0;
    inY          = '0;
    shownProduct = '0;

    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset high", 64'(outProductHigh), 64'd0);
    check("reset low", 64'(outProductLow), 64'd0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    runMul(32'd3, 32'd5, "3x5");
    check("3x5 constant", {outProductHigh, outProductLow}, 64'h0000_0000_0000_000F);
    runMul(32'hFFFF_FFF9, 32'd3, "-7x3");
    check("-7x3 constant", {outProductHigh, outProductLow}, 64'hFFFF_FFFF_FFFF_FFEB);
    runMul(32'h8000_0000, 32'h8000_0000, "minxmin");
    check("minxmin constant", {outProductHigh, outProductLow}, 64'h4000_0000_0000_0000);
    runMul(32'h7FFF_FFFF, 32'h8000_0000, "maxxmin");
    check("maxxmin constant", {outProductHigh, outProductLow}, 64'hC000_0000_8000_0000);
    runMul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "-1x-1");
    check("-1x-1 constant", {outProductHigh, outProductLow}, 64'h0000_0000_0000_0001);

    // Second start during ITER must be ignored.
    start = 1'b1;
    inX   = 32'd3;
    inY   = 32'd5;
    @(posedge clock);
    #1;
    start = 1'b0;
    doneCount = 0;
    doneValue = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (k == 5) begin
        start = 1'b1;
        inX   = 32'd9;
        inY   = 32'd9;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        doneCount++;
        doneValue = {outProductHigh, outProductLow};
      end
    end
    start = 1'b0;
    check("ignored start done count", 64'(doneCount), 64'd1);
    check("ignored start product", doneValue, 64'd15);
    shownProduct = 64'd15;

    // Clear at iteration 8 aborts with no done.
    start = 1'b1;
    inX   = $urandom;
    inY   = $urandom;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    clear = 1'b1;
    #1;
    check("clear immediate", {outProductHigh, outProductLow}, 64'd0);
    check("clear busy done", 64'({busy, done}), 64'd0);
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    shownProduct = '0;
    doneCount = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clock);
      if (done) doneCount++;
    end
    check("clear no done", 64'(doneCount), 64'd0);
    check("clear idle busy", 64'(busy), 64'd0);
    runMul(32'd2, 32'd2, "2x2 after clear");

    // Back-to-back: second start in the first IDLE cycle after done.
    runMul(32'd6, 32'd7, "6x7");
    runMul(32'hFFFF_FFFE, 32'hFFFF_FFFE, "-2x-2 back-to-back");
    check("-2x-2 constant", {outProductHigh, outProductLow}, 64'd4);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] rx;
      logic [31:0] ry;
      rx = $urandom;
      ry = $urandom;
      if (i == 3) rx = 32'h8000_0000;
      if (i == 7) ry = 32'h7FFF_FFFF;
      runMul(rx, ry, $sformatf("random %0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/booth_mul_sequencer.md
Name: booth_mul_sequencer

Overview:
- Iterative radix-4 (bit-pair Booth) signed 32x32 multiplier controller for the Mini SRC datapath. It retires one recoded bit-pair per clock, so a product takes 16 iterations.
- It latches operands on a start pulse, accumulates partial products, and delivers a 64-bit result as outProductHigh/outProductLow with a one-cycle done pulse.
- The CPU control unit uses it for the mul instruction, in place of a fully combinational array.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and at least 4. Iteration count is WIDTH/2.

Ports:
- clock  input  1  system clock, rising-edge.
- clear  input  1  asynchronous active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- inX  input  WIDTH  multiplicand, two's complement.
- inY  input  WIDTH  multiplier, two's complement.
- busy  output  1  high from acceptance until the done cycle inclusive.
- done  output  1  one-cycle pulse; product outputs valid and stable from this cycle.
- outProductHigh  output  WIDTH  upper half of the signed 2*WIDTH product.
- outProductLow  output  WIDTH  lower half of the product.

Behaviour:
- Reset: clock is single; clear is asynchronous, active-high.
  - While clear is high: state=IDLE, busy=0, done=0, outProductHigh=0, outProductLow=0, accumulator=0, iteration count=0.
  - Clear mid-operation aborts the operation with no done pulse.
- States: IDLE, ITER, DONE.
- IDLE to ITER, on an edge with start=1:
  - Capture mcand = sign-extend(inX) to 2*WIDTH.
  - Capture mplr = {inY, 1'b0} (WIDTH+1 bits, implicit Y[-1]=0).
  - Set acc=0, count=0, busy=1.
- ITER, each edge:
  - Recode mplr[2:0] into digit d in {-2,-1,0,+1,+2}:
    - 000 and 111 give 0.
    - 001 and 010 give +1.
    - 011 gives +2.
    - 100 gives -2.
    - 101 and 110 give -1.
  - acc += d*mcand, computed mod 2^(2*WIDTH). +2/-2 means mcand<<1; negative values use two's complement.
  - mcand <<= 2.
  - mplr arithmetic-shifts right by 2.
  - count += 1.
- ITER to DONE: on the edge where count reaches WIDTH/2-1, i.e. the 16th iteration.
  - The final acc is loaded into outProductHigh/outProductLow on that same edge.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE on the next edge. done is registered, not combinational.
- Latency: start sampled at edge T0 produces done high during the cycle after edge T16 (16 ITER edges). The next start can be accepted at edge T18 at the earliest.
- start while in ITER or DONE is ignored. It is neither queued nor errored.
- inX/inY changes after acceptance have no effect.
- Product outputs hold their last value until the next completion. They do not change during a subsequent ITER.
- Arithmetic: the accumulator is 2*WIDTH bits. Overflow cannot occur for signed operands; the most-negative times most-negative case is exact.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package mul_pkg holds:
  - state encoding (IDLE=2'd0, ITER=2'd1, DONE=2'd2);
  - digit encoding (3-bit signed: zero, pos1, pos2, neg1, neg2);
  - constant MUL_ITERS = WIDTH/2.
- One sub-module: booth_pair_recode. It is purely combinational: a 3-bit window in, a digit code out.
- The sequencer owns the state machine, the counter, the shift registers, and a 2*WIDTH adder with conditional invert plus carry-in for negative digits.

Test Plan:
- Multiply 3 by 5 -> hi=0x00000000, lo=0x0000000F; done exactly 17 cycles after the start edge; busy high for 17 cycles.
- Multiply -7 (0xFFFFFFF9) by 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Multiply 0x80000000 by 0x80000000 -> hi=0x40000000, lo=0x00000000.
- Multiply 0x7FFFFFFF by 0x80000000 -> hi=0xC0000000, lo=0x80000000.
- Multiply -1 by -1 -> hi=0, lo=1.
- Start 3 by 5, then pulse start with 9 by 9 at iteration 5 -> the second start is ignored; result is 15; a single done pulse.
- Start a multiply, then assert clear at iteration 8 -> all outputs 0 immediately; no done.
- Then start 2 by 2 -> lo=4 with normal latency.
- Back-to-back: start 6 by 7, then start 0xFFFFFFFE by 0xFFFFFFFE (-2 by -2) in the first IDLE cycle after done.
  - Required: outputs hold 42 through the second ITER; then lo=4, hi=0.
